hazard_ctrl: RTL

//  Pipeline hazard controller for the 5-stage core: watches decode (ID), EX and MEM stage

---
 rtl/hazard_ctrl.sv | 69 ++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/bubble/flush sequencing for the 5-stage core, with a data-memory freeze
// and saturating stall/flush counters.
module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_branch,
    input  logic             id_jr,
    input  logic             id_jump,
    input  logic             id_pcsrc,
    input  logic [4:0]       ex_dest,
    input  logic             ex_regwrite,
    input  logic             ex_memread,
    input  logic [4:0]       mem_dest,
    input  logic             mem_memread,
    input  logic             mem_busy,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             freeze,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    localparam logic [1:0] RUN = 2'd0, STALL2 = 2'd1, FREEZE = 2'd2;
    logic [1:0] saved, eff, len;
    logic       ex_hit, mem_hit, idop, act, stall;
    assign ex_hit  = (ex_dest != 5'd0) & ((id_use_rs & (ex_dest == id_rs)) | (id_use_rt & (ex_dest == id_rt)));
    assign mem_hit = (mem_dest != 5'd0) & ((id_use_rs & (mem_dest == id_rs)) | (id_use_rt & (mem_dest == id_rt)));
    assign idop    = id_branch | id_jr;
    always_comb begin
        len = (idop & ex_memread & ex_hit)   ? 2'd2 :
              (idop & ex_regwrite & ex_hit)  ? 2'd1 :
              (idop & mem_memread & mem_hit) ? 2'd1 :
              (!idop & ex_memread & ex_hit)  ? 2'd1 : 2'd0;
    end
    // Leaving a freeze behaves exactly like the state that was interrupted.
    assign eff         = (state == FREEZE) ? saved : state;
    assign act         = rst & !mem_busy;
    assign stall       = act & ((eff == STALL2) | ((eff == RUN) & (len != 2'd0)));
    assign pc_stall    = stall;
    assign ifid_stall  = stall;
    assign idex_bubble = stall;
    assign ifid_flush  = act & (eff == RUN) & (len == 2'd0) & (id_jump | id_jr | (id_branch & id_pcsrc));
    assign freeze      = rst & mem_busy;
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= RUN;
            saved     <= RUN;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (mem_busy) begin
                state <= FREEZE;
                saved <= eff;
            end else begin
                state <= ((eff == RUN) && (len == 2'd2)) ? STALL2 : RUN;
            end
            if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
            if (ifid_flush && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end
endmodule
